uart_frame_controller: RTL

Sequences the byte stream from the UART receiver (one-cycle data-ready pulse plus 8-bit data) into framed register-write commands. Frames are SYNC, ADDR, LEN, payload, CSUM. The payload is buffered internally and committed to a register-write port only after the checksum verifies. Sits between the UART receiver and the lab register file / peripheral bus.

---
 rtl/uart_frame_controller_pkg.sv | 30 +++
 rtl/uart_frame_controller_if.sv | 52 +++++
 rtl/uart_frame_controller_timer.sv | 40 ++++
 rtl/uart_frame_controller.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_pkg
//  Brief    : Shared state encoding, error codes and defaults for the UART
//             frame controller.
//  Revision : 1.0  initial release
// ============================================================================
package uart_frame_pkg;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    // Frame sequencer states
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ADDR    = 3'd1;
    localparam state_t ST_LEN     = 3'd2;
    localparam state_t ST_PAYLOAD = 3'd3;
    localparam state_t ST_CSUM    = 3'd4;
    localparam state_t ST_DRAIN   = 3'd5;

    // Cause of the most recent discarded frame
    localparam logic [1:0] ERR_CSUM    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h55;

endpackage
`default_nettype wire

// File: rtl/uart_frame_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_controller_if
//  Brief    : Byte input, register-write port and frame status bundle.
//             Optional macro FRAME_STATS_EN adds good_cnt / bad_cnt.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_frame_controller_if;

    logic       byte_valid;
    logic [7:0] byte_in;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;
`ifdef FRAME_STATS_EN
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    // Controller side: consumes bytes, issues register writes
    modport master (
        input  byte_valid, byte_in, wr_ready,
        output wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy,
        output good_cnt, bad_cnt
    );

    // Environment side: UART receiver plus register sink
    modport slave (
        output byte_valid, byte_in, wr_ready,
        input  wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy,
        input  good_cnt, bad_cnt
    );
`else
    // Controller side: consumes bytes, issues register writes
    modport master (
        input  byte_valid, byte_in, wr_ready,
        output wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy
    );

    // Environment side: UART receiver plus register sink
    modport slave (
        output byte_valid, byte_in, wr_ready,
        input  wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy
    );
`endif

endinterface
`default_nettype wire

// File: rtl/uart_frame_controller_timer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_timeout_timer
//  Brief    : Inter-byte watchdog. Counts cycles while running; o_expired is
//             asserted in the cycle whose closing edge would bring the count
//             to TIMEOUT_CYCLES, so the consumer reacts on that same edge.
//             A clear in that cycle (new byte) suppresses the expiry.
//  Revision : 1.0  initial release
// ============================================================================
module frame_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_clr,
    input  wire logic i_run,
    output logic      o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_terminal = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_limit    = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;

    // Idle-cycle counter: cleared by any byte or whenever not running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_run) begin
            r_cnt <= '0;
        end else if (r_cnt != c_limit) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired = i_run && !i_clr && (r_cnt == c_terminal);

endmodule
`default_nettype wire

// File: rtl/uart_frame_controller.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_controller
//  Brief    : Turns SYNC/ADDR/LEN/payload/CSUM byte frames from a UART
//             receiver into checksum-verified register writes.
//             Optional macro FRAME_STATS_EN adds saturating good/bad frame
//             counters on the interface.
//  Revision : 1.0  initial release
// ============================================================================
module uart_frame_controller
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN        = 8,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    uart_frame_controller_if.master bus
);

    localparam logic [7:0] c_max_len = 8'(MAX_LEN);

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_base;
    logic [7:0] r_len;
    logic [7:0] r_sum;
    logic [3:0] r_idx;
    logic       r_overrun;
    logic [7:0] r_buf [16];

    logic       r_wr_en;
    logic [7:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic       r_frame_ok;
    logic       r_frame_err;
    logic [1:0] r_err_code;
    logic       r_busy;

    logic       w_wr_en_nxt;
    logic [7:0] w_wr_addr_nxt;
    logic [7:0] w_wr_data_nxt;
    logic       w_frame_ok_nxt;
    logic       w_frame_err_nxt;
    logic [1:0] w_err_code_nxt;

    logic       w_bv;
    logic [7:0] w_byte;
    logic       w_run;
    logic       w_timeout;
    logic       w_last;
    logic       w_accept;
    logic       w_sum_match;

    assign w_bv        = bus.byte_valid;
    assign w_byte      = bus.byte_in;
    assign w_run       = (r_state == ST_ADDR) || (r_state == ST_LEN) ||
                         (r_state == ST_PAYLOAD) || (r_state == ST_CSUM);
    // r_idx is the payload index while filling and the write index while draining
    assign w_last      = (({4'd0, r_idx} + 8'd1) == r_len);
    assign w_accept    = r_wr_en && bus.wr_ready;
    assign w_sum_match = (w_byte == r_sum);

    frame_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_bv),
        .i_run     (w_run),
        .o_expired (w_timeout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a byte always takes priority over a coincident timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_bv && (w_byte == SYNC_BYTE)) w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                if (w_bv)           w_state_nxt = ST_LEN;
                else if (w_timeout) w_state_nxt = ST_IDLE;
            end
            ST_LEN: begin
                if (w_bv) begin
                    if (w_byte > c_max_len)  w_state_nxt = ST_IDLE;
                    else if (w_byte == 8'd0) w_state_nxt = ST_CSUM;
                    else                     w_state_nxt = ST_PAYLOAD;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (w_bv) begin
                    if (w_last) w_state_nxt = ST_CSUM;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CSUM: begin
                if (w_bv) begin
                    if (w_sum_match && (r_len != 8'd0)) w_state_nxt = ST_DRAIN;
                    else                                w_state_nxt = ST_IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (w_accept && w_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: next values of the registered write port and status pulses
    always_comb begin
        w_wr_en_nxt     = r_wr_en;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;
        w_frame_ok_nxt  = 1'b0;
        w_frame_err_nxt = 1'b0;
        w_err_code_nxt  = r_err_code;
        case (r_state)
            ST_ADDR, ST_PAYLOAD: begin
                if (!w_bv && w_timeout) begin
                    w_frame_err_nxt = 1'b1;
                    w_err_code_nxt  = ERR_TIMEOUT;
                end
            end
            ST_LEN: begin
                if (w_bv && (w_byte > c_max_len)) begin
                    w_frame_err_nxt = 1'b1;
                    w_err_code_nxt  = ERR_LEN;
                end else if (!w_bv && w_timeout) begin
                    w_frame_err_nxt = 1'b1;
                    w_err_code_nxt  = ERR_TIMEOUT;
                end
            end
            ST_CSUM: begin
                if (w_bv) begin
                    if (!w_sum_match) begin
                        w_frame_err_nxt = 1'b1;
                        w_err_code_nxt  = ERR_CSUM;
                    end else if (r_len == 8'd0) begin
                        w_frame_ok_nxt  = 1'b1;
                    end else begin
                        w_wr_en_nxt     = 1'b1;
                        w_wr_addr_nxt   = r_base;
                        w_wr_data_nxt   = r_buf[0];
                    end
                end else if (w_timeout) begin
                    w_frame_err_nxt = 1'b1;
                    w_err_code_nxt  = ERR_TIMEOUT;
                end
            end
            ST_DRAIN: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_wr_en_nxt = 1'b0;
                        // A byte landing on the final accept cycle is also an overrun
                        if (r_overrun || w_bv) begin
                            w_frame_err_nxt = 1'b1;
                            w_err_code_nxt  = ERR_OVERRUN;
                        end else begin
                            w_frame_ok_nxt  = 1'b1;
                        end
                    end else begin
                        w_wr_addr_nxt = r_base + {4'd0, r_idx} + 8'd1;
                        w_wr_data_nxt = r_buf[r_idx + 4'd1];
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en     <= 1'b0;
            r_wr_addr   <= 8'd0;
            r_wr_data   <= 8'd0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= 2'd0;
            r_busy      <= 1'b0;
        end else begin
            r_wr_en     <= w_wr_en_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_frame_ok  <= w_frame_ok_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_err_code  <= w_err_code_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    // Frame header, running checksum, index and overrun tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base    <= 8'd0;
            r_len     <= 8'd0;
            r_sum     <= 8'd0;
            r_idx     <= 4'd0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_idx     <= 4'd0;
                    r_overrun <= 1'b0;
                end
                ST_ADDR: begin
                    if (w_bv) begin
                        r_base <= w_byte;
                        r_sum  <= w_byte;
                    end
                end
                ST_LEN: begin
                    if (w_bv) begin
                        r_len <= w_byte;
                        r_sum <= r_sum + w_byte;
                        r_idx <= 4'd0;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_bv) begin
                        r_sum <= r_sum + w_byte;
                        r_idx <= r_idx + 4'd1;
                    end
                end
                ST_CSUM: begin
                    if (w_bv) r_idx <= 4'd0;
                end
                ST_DRAIN: begin
                    if (w_bv) r_overrun <= 1'b1;
                    if (w_accept && !w_last) r_idx <= r_idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Payload buffer; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if ((r_state == ST_PAYLOAD) && w_bv) r_buf[r_idx] <= w_byte;
    end

    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.frame_ok  = r_frame_ok;
    assign bus.frame_err = r_frame_err;
    assign bus.err_code  = r_err_code;
    assign bus.busy      = r_busy;

`ifdef FRAME_STATS_EN
    logic [15:0] r_good_cnt;
    logic [15:0] r_bad_cnt;

    // Saturating counts of committed and discarded frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_good_cnt <= 16'd0;
            r_bad_cnt  <= 16'd0;
        end else begin
            if (w_frame_ok_nxt && (r_good_cnt != 16'hFFFF)) r_good_cnt <= r_good_cnt + 16'd1;
            if (w_frame_err_nxt && (r_bad_cnt != 16'hFFFF)) r_bad_cnt <= r_bad_cnt + 16'd1;
        end
    end

    assign bus.good_cnt = r_good_cnt;
    assign bus.bad_cnt  = r_bad_cnt;
`endif

endmodule
`default_nettype wire
